pc_fetch_ctrl: RTL

- Fetch sequencer that owns the architectural fetch PC.
- Issues one instruction-memory request at a time over a valid/ready request channel and waits for a valid-only response.
- Presents the fetched instruction and its PC to decode with a valid/ready handshake.
- Applies branch/jump redirects from execute at any point, including while a fetch is in flight.

---
 rtl/pc_fetch_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer owning the architectural fetch PC: one outstanding imem request, decode handoff, redirects.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h80000000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0] perf_inst_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic [31:0] redir_pc;
  logic        consume;
  logic        discard;
  logic        unused_redir_lsbs;

  assign redir_pc          = {redirect_pc[31:2], 2'b00};
  assign unused_redir_lsbs = ^redirect_pc[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    consume      = 1'b0;
    discard      = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = redir_pc;
      end

      S_REQ: begin
        if (redirect_valid) pc_d = redir_pc;
        if (imem_req_ready) begin
          state_d = S_WAIT;
          // The request already left with the old pc; its response must be thrown away.
          if (redirect_valid) drop_d = 1'b1;
        end
      end

      S_WAIT: begin
        if (imem_resp_valid) begin
          if (drop_q || redirect_valid) begin
            discard = 1'b1;
            drop_d  = 1'b0;
            state_d = S_REQ;
            if (redirect_valid) pc_d = redir_pc;
          end else begin
            inst_data_d  = imem_resp_data;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d   = redir_pc;
          drop_d = 1'b1;
        end
      end

      S_HOLD: begin
        consume = inst_ready;
        if (redirect_valid) begin
          pc_d         = redir_pc;
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end else if (inst_ready) begin
          pc_d         = pc_q + 32'(PC_STEP);
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;
  assign pc             = pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [63:0] perf_inst_cnt_q, perf_inst_cnt_d;
  logic [31:0] perf_drop_cnt_q, perf_drop_cnt_d;

  always_comb begin
    perf_inst_cnt_d = perf_inst_cnt_q;
    perf_drop_cnt_d = perf_drop_cnt_q;
    if (consume) perf_inst_cnt_d = perf_inst_cnt_q + 64'd1;
    if (discard) perf_drop_cnt_d = perf_drop_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_inst_cnt_q <= '0;
      perf_drop_cnt_q <= '0;
    end else begin
      perf_inst_cnt_q <= perf_inst_cnt_d;
      perf_drop_cnt_q <= perf_drop_cnt_d;
    end
  end

  assign perf_inst_cnt = perf_inst_cnt_q;
  assign perf_drop_cnt = perf_drop_cnt_q;
`else
  logic unused_perf_events;
  assign unused_perf_events = consume ^ discard;
`endif

endmodule
